// File: rtl/esp_spi_pkg.sv
// Shared types and constants for the ESP8266 SPI frame sequencer.
package esp_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    PAYLOAD,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] ESP_CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] ESP_ADDR_BASE      = 8'h00;

  // Bytes on the wire: command + address + payload (+ optional checksum).
  function automatic int frame_len(input int p, input bit csum);
    return 2 + p + (csum ? 1 : 0);
  endfunction

endpackage

// File: rtl/esp_spi_frame_sequencer_if.sv
// Byte-wide write interface between the frame sequencer and the SPI master core.
interface esp_spi_frame_sequencer_if;
  // Handshake: the core raises di_req when it can take a byte. The sequencer
  // then presents data_byte with wren=1 and holds both stable until it sees a
  // rising edge on write_ack, after which wren drops for at least one cycle.
  logic [7:0] data_byte;
  logic       wren;
  logic       di_req;
  logic       write_ack;

  modport master (output data_byte, output wren, input di_req, input write_ack);
  modport slave  (input data_byte, input wren, output di_req, output write_ack);
endinterface

// File: rtl/esp_spi_byte_select.sv
// Combinational payload byte mux: returns byte[index] of the latched shadow payload.
module esp_spi_byte_select #(
  parameter int P     = 32,
  parameter int IDX_W = $clog2(P + 1)
) (
  input  logic [8*P-1:0]   shadow,
  input  logic [IDX_W-1:0] index,
  output logic [7:0]       byte_out
);

  always_comb begin
    byte_out = 8'h00;
    for (int k = 0; k < P; k++) begin
      if (index == k[IDX_W-1:0]) byte_out = shadow[8*k +: 8];
    end
  end

endmodule

// File: rtl/esp_spi_frame_sequencer.sv
// Serialises a latched payload into a CMD/ADDR/payload frame for the ESP8266 SPI slave.
// Define ESP_SPI_CHECKSUM_EN to append an XOR checksum byte after the payload.
module esp_spi_frame_sequencer
  import esp_spi_pkg::*;
#(
  parameter int         NUM_WORDS  = 8,
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] CMD_BYTE   = ESP_CMD_WRITE_DATA,
  parameter logic [7:0] ADDR_BYTE  = ESP_ADDR_BASE
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [8*NUM_WORDS*WORD_BYTES-1:0] data,
  input  logic                              data_ready,
  esp_spi_frame_sequencer_if.master         spi,
  output logic                              busy,
  output logic                              frame_done,
  output logic [7:0]                        dropped_count,
  output state_t                            fsm_state
);

  localparam int P     = NUM_WORDS * WORD_BYTES;
  localparam int IDX_W = $clog2(P + 1);

  state_t             state_q, state_d;
  logic [8*P-1:0]     shadow_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wren_q;
  logic [7:0]         byte_q;
  logic               ack_prev_q;
  logic [7:0]         drop_q;
  logic [7:0]         payload_byte;
  logic [7:0]         issue_byte;
`ifdef ESP_SPI_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  logic ack_edge, in_frame, accept, acked, issue, last_payload;

  assign ack_edge     = spi.write_ack & ~ack_prev_q;
  assign in_frame     = (state_q inside {CMD, ADDR, PAYLOAD, CSUM});
  assign accept       = data_ready && (state_q == IDLE || state_q == DONE);
  assign acked        = ack_edge && wren_q && in_frame;
  assign issue        = spi.di_req && !wren_q && in_frame;
  assign last_payload = (idx_q == IDX_W'(P - 1));

  esp_spi_byte_select #(.P(P), .IDX_W(IDX_W)) u_byte_select (
    .shadow   (shadow_q),
    .index    (idx_q),
    .byte_out (payload_byte)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_ready) state_d = CMD;
      CMD:     if (acked) state_d = ADDR;
      ADDR:    if (acked) state_d = PAYLOAD;
      PAYLOAD: if (acked && last_payload) begin
`ifdef ESP_SPI_CHECKSUM_EN
                 state_d = CSUM;
`else
                 state_d = DONE;
`endif
               end
`ifdef ESP_SPI_CHECKSUM_EN
      CSUM:    if (acked) state_d = DONE;
`endif
      DONE:    state_d = data_ready ? CMD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_byte = CMD_BYTE;
    case (state_q)
      ADDR:    issue_byte = ADDR_BYTE;
      PAYLOAD: issue_byte = payload_byte;
`ifdef ESP_SPI_CHECKSUM_EN
      CSUM:    issue_byte = csum_q;
`endif
      default: issue_byte = CMD_BYTE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      wren_q     <= 1'b0;
      byte_q     <= 8'h00;
      ack_prev_q <= 1'b0;
      drop_q     <= 8'h00;
`ifdef ESP_SPI_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      ack_prev_q <= spi.write_ack;
      if (accept) begin
        shadow_q <= data;
        idx_q    <= '0;
`ifdef ESP_SPI_CHECKSUM_EN
        csum_q   <= 8'h00;
`endif
      end
      // An ack always wins; issue needs wren low so the two never collide.
      if (acked) begin
        wren_q <= 1'b0;
        if (state_q == PAYLOAD) begin
          if (!last_payload) idx_q <= idx_q + 1'b1;
`ifdef ESP_SPI_CHECKSUM_EN
          csum_q <= csum_q ^ byte_q;
`endif
        end
      end else if (issue) begin
        wren_q <= 1'b1;
        byte_q <= issue_byte;
      end
      if (data_ready && in_frame && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign spi.wren      = wren_q;
  assign spi.data_byte = byte_q;
  assign busy          = in_frame;
  assign frame_done    = (state_q == DONE);
  assign dropped_count = drop_q;
  assign fsm_state     = state_q;

endmodule
